// File: rtl/count_bcd_pkg.sv
// Shared types and constants for the counter-to-BCD converter.
package count_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned ADD3_THRESH = 5;

  // Decimal digits needed to represent the largest WIDTH-bit value.
  function automatic int unsigned min_digits(input int unsigned width);
    logic [63:0] max_val;
    int unsigned n;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    n = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_add3
  import count_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= BCD_DIGIT_W'(ADD3_THRESH)) ? i_digit + BCD_DIGIT_W'(3) : i_digit;

endmodule

// File: rtl/count_bcd_converter.sv
// Iterative binary-to-BCD converter, one double-dabble step per clock,
// with valid/ready handshakes on input and output.
module count_bcd_converter
  import count_bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_bin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd
);

  localparam int unsigned BcdW  = BCD_DIGIT_W * DIGITS;
  localparam int unsigned StepW = $clog2(WIDTH + 1);

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
    $error("count_bcd_converter: DIGITS too small for WIDTH");
  end

  state_e            r_state, w_state_d;
  logic [BcdW-1:0]   r_scratch, w_scratch_d;
  logic [WIDTH-1:0]  r_shift, w_shift_d;
  logic [StepW-1:0]  r_step, w_step_d;
  logic [BcdW-1:0]   r_out_bcd, w_out_bcd_d;

  logic [BcdW-1:0]       w_corr;
  logic [BcdW+WIDTH-1:0] w_cat;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit(r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit(w_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Correct first, then shift so the binary MSB lands in digit-0 bit 0.
  assign w_cat = {w_corr, r_shift} << 1;

  always_comb begin
    w_state_d   = r_state;
    w_scratch_d = r_scratch;
    w_shift_d   = r_shift;
    w_step_d    = r_step;
    w_out_bcd_d = r_out_bcd;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_shift_d   = in_bin;
          w_scratch_d = '0;
          w_step_d    = StepW'(WIDTH);
          w_state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {w_scratch_d, w_shift_d} = w_cat;
        w_step_d = r_step - StepW'(1);
        if (r_step == StepW'(1)) begin
          w_out_bcd_d = w_cat[BcdW+WIDTH-1 -: BcdW];
          w_state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_scratch <= '0;
      r_shift   <= '0;
      r_step    <= '0;
      r_out_bcd <= '0;
    end else begin
      r_state   <= w_state_d;
      r_scratch <= w_scratch_d;
      r_shift   <= w_shift_d;
      r_step    <= w_step_d;
      r_out_bcd <= w_out_bcd_d;
    end
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign out_bcd   = r_out_bcd;

endmodule

// File: tb/tb_count_bcd_converter.sv
// Self-checking bench for count_bcd_converter (8-bit/3-digit and 4-bit/2-digit).
module tb_count_bcd_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_bin;
  logic [11:0] out_bcd;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  in_bin4;
  logic [7:0]  out_bcd4;

  int checks = 0;
  int errors = 0;

  count_bcd_converter #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd)
  );

  count_bcd_converter #(.WIDTH(4), .DIGITS(2)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_bin(in_bin4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_bcd(out_bcd4)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
  } vec_t;

  // Reference: decimal digits by plain division.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One conversion on the 8-bit DUT; holds out_ready low for `hold` cycles
  // while pulsing in_valid, which must not be accepted.
  task automatic convert(input logic [7:0] v, input logic [11:0] exp, input int hold);
    int lat;
    in_bin   = v;
    in_valid = 1'b1;
    check("accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_bin   = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check("latency", lat, 8);
    check("result", out_bcd, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      in_bin   = 8'($urandom);
      step();
      check("hold_valid", out_valid, 1);
      check("hold_bcd", out_bcd, exp);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("idle_ready", in_ready, 1);
    check("bcd_kept", out_bcd, exp);
  endtask

  task automatic convert4(input logic [3:0] v);
    int lat;
    in_bin4   = v;
    in_valid4 = 1'b1;
    check("w4_accept_ready", in_ready4, 1);
    step();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      step();
      lat++;
    end
    check("w4_latency", lat, 4);
    check("w4_result", out_bcd4, ref_bcd(v) & 16'h00ff);
    out_ready4 = 1'b1;
    step();
    out_ready4 = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    logic [15:0] q[$];
    logic [15:0] exp_q;
    int cnt, got, cyc;

    vecs[0] = '{bin: 8'd0,   bcd: 12'h000};
    vecs[1] = '{bin: 8'd255, bcd: 12'h255};
    vecs[2] = '{bin: 8'd128, bcd: 12'h128};
    vecs[3] = '{bin: 8'd99,  bcd: 12'h099};
    vecs[4] = '{bin: 8'd10,  bcd: 12'h010};
    vecs[5] = '{bin: 8'd109, bcd: 12'h109};

    rst = 1'b1;
    in_valid = 1'b0; in_bin = '0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_bin4 = '0; out_ready4 = 1'b0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bcd", out_bcd, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);
    step();

    foreach (vecs[i]) convert(vecs[i].bin, vecs[i].bcd, 0);

    // Backpressure on 42 with ignored in_valid pulses.
    convert(8'd42, 12'h042, 5);
    step();
    check("no_spurious_accept", out_valid, 0);

    // Reset during the 4th SHIFT step of 200.
    in_bin = 8'd200;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("midrst_valid", out_valid, 0);
    check("midrst_bcd", out_bcd, 0);
    check("midrst_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", in_ready, 1);
    repeat (10) step();
    check("midrst_no_partial", out_valid, 0);
    convert(8'd7, 12'h007, 1);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      convert(v, ref_bcd(v), $urandom_range(0, 3));
    end

    // Counter-driven stream with out_ready tied high.
    cnt = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    while (got < 256 && cyc < 5000) begin
      in_valid = (cnt < 256);
      in_bin   = 8'(cnt);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("stream_spurious", 1, 0);
        else begin
          exp_q = q.pop_front();
          check("stream", out_bcd, exp_q);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_bcd(cnt));
        cnt++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_count", got, 256);
    check("stream_drained", q.size(), 0);
    step();
    step();

    for (int v = 0; v < 16; v++) convert4(4'(v));
    check("w4_idle", out_valid4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
